cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/cache_arbiter.sv | 155 +++++++++++++++
 tb/tb_cache_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// ----------------------------------------------------------------------------
// cache_arbiter
//   Shares a single L2 port between an I-cache (read only) and a D-cache
//   (read or writeback). One transaction is outstanding at a time. After
//   each completion the arbiter spends one RECOVER cycle without granting.
//   This gives the served requester time to drop its level request before
//   the next arbitration.
//
// Parameters
//   FAIR       : 1 = alternate on contention, 0 = D-side always wins
//
// Ports
//   clk        : sole clock, rising edge
//   rst_n      : synchronous active-low reset
//   i_read     : I-cache read request (level, held until i_resp)
//   i_address  : I-cache line address
//   i_rdata    : line returned to the I-cache (pass-through of l2_rdata)
//   i_resp     : one-cycle completion pulse to the I-cache
//   d_read     : D-cache read request (level, held until d_resp)
//   d_write    : D-cache writeback request (level, wins over d_read)
//   d_address  : D-cache line address
//   d_wdata    : D-cache writeback line
//   d_rdata    : line returned to the D-cache (pass-through of l2_rdata)
//   d_resp     : one-cycle completion pulse to the D-cache
//   l2_read    : registered read request to L2
//   l2_write   : registered write request to L2
//   l2_address : registered L2 address, latched at grant
//   l2_wdata   : registered L2 write data, latched at grant
//   l2_rdata   : L2 read data, valid with l2_resp
//   l2_resp    : L2 completion pulse
// ----------------------------------------------------------------------------
module cache_arbiter #(
    parameter int unsigned FAIR = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_read,
    input  logic [15:0]  i_address,
    output logic [127:0] i_rdata,
    output logic         i_resp,
    input  logic         d_read,
    input  logic         d_write,
    input  logic [15:0]  d_address,
    input  logic [127:0] d_wdata,
    output logic [127:0] d_rdata,
    output logic         d_resp,
    output logic         l2_read,
    output logic         l2_write,
    output logic [15:0]  l2_address,
    output logic [127:0] l2_wdata,
    input  logic [127:0] l2_rdata,
    input  logic         l2_resp
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SERVE_I = 2'd1;
    localparam logic [1:0] SERVE_D = 2'd2;
    localparam logic [1:0] RECOVER = 2'd3;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    logic [1:0]   state_q,      state_d;
    logic         last_grant_q, last_grant_d;
    logic         l2_read_q,    l2_read_d;
    logic         l2_write_q,   l2_write_d;
    logic [15:0]  l2_address_q, l2_address_d;
    logic [127:0] l2_wdata_q,   l2_wdata_d;

    logic i_pend;
    logic d_pend;
    logic pick_d;

    assign i_pend = i_read;
    assign d_pend = d_read | d_write;

    // D wins when it is alone. Under contention it wins if fairness is off,
    // or if I was the side served last.
    assign pick_d = d_pend & (~i_pend | (FAIR == 32'd0) | (last_grant_q == GRANT_I));

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        l2_read_d    = l2_read_q;
        l2_write_d   = l2_write_q;
        l2_address_d = l2_address_q;
        l2_wdata_d   = l2_wdata_q;
        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    state_d      = SERVE_D;
                    l2_address_d = d_address;
                    l2_wdata_d   = d_wdata;
                    // Read and write together are treated as a writeback only.
                    l2_write_d   = d_write;
                    l2_read_d    = d_read & ~d_write;
                end else if (i_pend) begin
                    state_d      = SERVE_I;
                    l2_address_d = i_address;
                    l2_read_d    = 1'b1;
                    l2_write_d   = 1'b0;
                end
            end
            SERVE_I: begin
                if (l2_resp) begin
                    state_d      = RECOVER;
                    last_grant_d = GRANT_I;
                    l2_read_d    = 1'b0;
                    l2_write_d   = 1'b0;
                end
            end
            SERVE_D: begin
                if (l2_resp) begin
                    state_d      = RECOVER;
                    last_grant_d = GRANT_D;
                    l2_read_d    = 1'b0;
                    l2_write_d   = 1'b0;
                end
            end
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_I;
            l2_read_q    <= 1'b0;
            l2_write_q   <= 1'b0;
            l2_address_q <= '0;
            l2_wdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            l2_read_q    <= l2_read_d;
            l2_write_q   <= l2_write_d;
            l2_address_q <= l2_address_d;
            l2_wdata_q   <= l2_wdata_d;
        end
    end

    // The completion pulses come straight from l2_resp while serving. They
    // are gated by rst_n so that no pulse appears while reset is held.
    assign i_resp     = rst_n & (state_q == SERVE_I) & l2_resp;
    assign d_resp     = rst_n & (state_q == SERVE_D) & l2_resp;
    assign i_rdata    = l2_rdata;
    assign d_rdata    = l2_rdata;

    assign l2_read    = l2_read_q;
    assign l2_write   = l2_write_q;
    assign l2_address = l2_address_q;
    assign l2_wdata   = l2_wdata_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cache_arbiter
//   Two arbiters (FAIR=1 and FAIR=0) are driven with identical stimulus. A
//   transaction-level model of each one predicts every output on every cycle.
//   Directed scenarios add literal expectations, followed by a random phase.
// ----------------------------------------------------------------------------
module tb_cache_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_read, d_read, d_write, l2_resp;
    logic [15:0]  i_address, d_address;
    logic [127:0] d_wdata, l2_rdata;

    logic [1:0]         i_resp_w, d_resp_w, l2_read_w, l2_write_w;
    logic [1:0][127:0]  i_rdata_w, d_rdata_w, l2_wdata_w;
    logic [1:0][15:0]   l2_address_w;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    cache_arbiter #(.FAIR(1)) dut_fair (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata_w[0]), .i_resp(i_resp_w[0]),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata_w[0]), .d_resp(d_resp_w[0]),
        .l2_read(l2_read_w[0]), .l2_write(l2_write_w[0]), .l2_address(l2_address_w[0]),
        .l2_wdata(l2_wdata_w[0]), .l2_rdata(l2_rdata), .l2_resp(l2_resp)
    );

    cache_arbiter #(.FAIR(0)) dut_prio (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata_w[1]), .i_resp(i_resp_w[1]),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata_w[1]), .d_resp(d_resp_w[1]),
        .l2_read(l2_read_w[1]), .l2_write(l2_write_w[1]), .l2_address(l2_address_w[1]),
        .l2_wdata(l2_wdata_w[1]), .l2_rdata(l2_rdata), .l2_resp(l2_resp)
    );

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ------------------------------------------------------------------
    // Transaction-level model. owner: 0 none, 1 = I-cache, 2 = D-cache.
    // cool = number of no-grant cycles still owed after a completion.
    // ------------------------------------------------------------------
    int           owner [2];
    int           cool  [2];
    int           last_owner [2];
    logic         m_rd [2];
    logic         m_wr [2];
    logic [15:0]  m_addr [2];
    logic [127:0] m_wdata [2];

    initial begin
        for (int m = 0; m < 2; m++) begin
            owner[m] = 0; cool[m] = 0; last_owner[m] = 1;
            m_rd[m] = 1'b0; m_wr[m] = 1'b0; m_addr[m] = '0; m_wdata[m] = '0;
        end
    end

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (rst_n !== 1'b1) begin
                owner[m] = 0; cool[m] = 0; last_owner[m] = 1;
                m_rd[m] = 1'b0; m_wr[m] = 1'b0; m_addr[m] = '0; m_wdata[m] = '0;
            end else if (owner[m] != 0) begin
                if (l2_resp) begin
                    last_owner[m] = owner[m];
                    owner[m] = 0;
                    cool[m] = 1;
                    m_rd[m] = 1'b0; m_wr[m] = 1'b0;
                end
            end else if (cool[m] > 0) begin
                cool[m] = cool[m] - 1;
            end else begin
                int winner;
                bit want_i, want_d;
                want_i = i_read;
                want_d = d_read | d_write;
                winner = 0;
                if (want_i && want_d)
                    winner = (m == 1) ? 2 : ((last_owner[m] == 2) ? 1 : 2);
                else if (want_d)
                    winner = 2;
                else if (want_i)
                    winner = 1;
                owner[m] = winner;
                if (winner == 2) begin
                    m_addr[m] = d_address; m_wdata[m] = d_wdata;
                    m_wr[m] = d_write; m_rd[m] = !d_write;
                end else if (winner == 1) begin
                    m_addr[m] = i_address; m_rd[m] = 1'b1; m_wr[m] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            #4;
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("i_resp[%0d]", m), 128'(i_resp_w[m]),
                    128'(rst_n && owner[m] == 1 && l2_resp));
                chk($sformatf("d_resp[%0d]", m), 128'(d_resp_w[m]),
                    128'(rst_n && owner[m] == 2 && l2_resp));
                chk($sformatf("i_rdata[%0d]", m), i_rdata_w[m], l2_rdata);
                chk($sformatf("d_rdata[%0d]", m), d_rdata_w[m], l2_rdata);
                chk($sformatf("l2_read[%0d]", m), 128'(l2_read_w[m]), 128'(m_rd[m]));
                chk($sformatf("l2_write[%0d]", m), 128'(l2_write_w[m]), 128'(m_wr[m]));
                chk($sformatf("l2_address[%0d]", m), 128'(l2_address_w[m]), 128'(m_addr[m]));
                chk($sformatf("l2_wdata[%0d]", m), l2_wdata_w[m], m_wdata[m]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers (stimulus changes only right after a negedge or at
    // negedge+2; the model compare samples at negedge+4).
    // ------------------------------------------------------------------
    task automatic wait_grant(string name);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #2;
            if (l2_read_w[0] || l2_write_w[0]) return;
        end
        chk({name, "_grant_timeout"}, 128'd0, 128'd1);
    endtask

    task automatic respond(int lat, logic [127:0] data);
        repeat (lat) @(negedge clk);
        l2_resp = 1'b1;
        l2_rdata = data;
        #2;
    endtask

    localparam logic [127:0] PAT_A5 = {16{8'hA5}};
    localparam logic [127:0] PAT_0F = {16{8'h0F}};

    int q0 [$];
    int q1 [$];
    int i_in_prio;

    initial begin
        rst_n = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; l2_resp = 1'b0;
        i_address = '0; d_address = '0; d_wdata = '0; l2_rdata = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        #2;
        chk("reset_l2_read", 128'(l2_read_w[0]), 128'd0);
        chk("reset_l2_address", 128'(l2_address_w[0]), 128'd0);
        rst_n = 1'b1;

        // I-read alone, L2 latency 3
        @(negedge clk);
        i_read = 1'b1; i_address = 16'h1234;
        wait_grant("iread");
        chk("iread_l2_address", 128'(l2_address_w[0]), 128'h1234);
        respond(3, PAT_A5);
        chk("iread_i_resp", 128'(i_resp_w[0]), 128'd1);
        chk("iread_i_rdata", i_rdata_w[0], PAT_A5);
        chk("iread_d_resp", 128'(d_resp_w[0]), 128'd0);
        @(negedge clk);
        l2_resp = 1'b0; i_read = 1'b0; #2;
        chk("iread_pulse_end", 128'(i_resp_w[0]), 128'd0);
        repeat (2) @(negedge clk);

        // D writeback with read also high; inputs wander mid-transaction
        d_write = 1'b1; d_read = 1'b1; d_address = 16'h8000; d_wdata = PAT_0F;
        wait_grant("dwb");
        chk("dwb_l2_write", 128'(l2_write_w[0]), 128'd1);
        chk("dwb_l2_read", 128'(l2_read_w[0]), 128'd0);
        d_address = 16'h5555; d_wdata = {4{32'hDEADBEEF}};
        respond(2, '0);
        chk("dwb_l2_wdata_held", l2_wdata_w[0], PAT_0F);
        chk("dwb_d_resp", 128'(d_resp_w[0]), 128'd1);
        chk("dwb_i_resp", 128'(i_resp_w[0]), 128'd0);
        @(negedge clk);
        l2_resp = 1'b0; d_write = 1'b0; d_read = 1'b0;
        repeat (2) @(negedge clk);

        // Contention from reset release, L2 answers immediately every cycle
        rst_n = 1'b0; i_read = 1'b1; d_read = 1'b1; i_address = 16'h0111;
        d_address = 16'h0222; l2_resp = 1'b1; l2_rdata = PAT_A5;
        @(negedge clk);
        rst_n = 1'b1;
        i_in_prio = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #2;
            if (i_resp_w[0]) q0.push_back(1);
            if (d_resp_w[0]) q0.push_back(2);
            if (i_resp_w[1]) i_in_prio++;
            if (d_resp_w[1]) q1.push_back(2);
        end
        chk("fair_grant0", 128'(q0[0]), 128'd2);
        chk("fair_grant1", 128'(q0[1]), 128'd1);
        chk("fair_grant2", 128'(q0[2]), 128'd2);
        chk("fair_grant3", 128'(q0[3]), 128'd1);
        chk("prio_d_count", 128'(q1.size()), 128'd7);
        chk("prio_i_starved", 128'(i_in_prio), 128'd0);
        l2_resp = 1'b0; i_read = 1'b0; d_read = 1'b0;
        repeat (3) @(negedge clk);

        // Reset two cycles after an I grant, late l2_resp after release
        i_read = 1'b1; i_address = 16'h4444;
        wait_grant("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0; i_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        l2_resp = 1'b1; #2;
        chk("rst_no_i_resp", 128'(i_resp_w[0]), 128'd0);
        chk("rst_l2_read", 128'(l2_read_w[0]), 128'd0);
        @(negedge clk);
        l2_resp = 1'b0; i_read = 1'b1; i_address = 16'h4446;
        wait_grant("rst_new");
        chk("rst_new_addr", 128'(l2_address_w[0]), 128'h4446);
        respond(1, {4{32'h01234567}});
        chk("rst_new_i_resp", 128'(i_resp_w[0]), 128'd1);
        @(negedge clk);
        l2_resp = 1'b0; i_read = 1'b0;
        repeat (2) @(negedge clk);

        // Spurious l2_resp in IDLE, then I drops its request mid-service
        l2_resp = 1'b1; #2;
        chk("spur_i_resp", 128'(i_resp_w[0]), 128'd0);
        chk("spur_d_resp", 128'(d_resp_w[0]), 128'd0);
        @(negedge clk);
        l2_resp = 1'b0; i_read = 1'b1; i_address = 16'h0ABC;
        wait_grant("drop");
        @(negedge clk);
        i_read = 1'b0;
        respond(2, PAT_0F);
        chk("drop_i_resp", 128'(i_resp_w[0]), 128'd1);
        @(negedge clk);
        l2_resp = 1'b0;
        repeat (2) @(negedge clk);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst_n     = ($urandom_range(0, 99) != 0);
            i_read    = ($urandom_range(0, 2) != 0);
            d_read    = $urandom_range(0, 1) != 0;
            d_write   = ($urandom_range(0, 3) == 0);
            i_address = 16'($urandom);
            d_address = 16'($urandom);
            d_wdata   = {$urandom, $urandom, $urandom, $urandom};
            l2_rdata  = {$urandom, $urandom, $urandom, $urandom};
            l2_resp   = ($urandom_range(0, 2) == 0);
        end
        @(negedge clk);
        #6;
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
